// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: XGMII characters, 64b/66b block types and codes, TX state/class enums.
package pcs_pkg;

    localparam int unsigned LANES = 8;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] BT_C  = 8'h1E;
    localparam logic [7:0] BT_S0 = 8'h78;
    localparam logic [7:0] BT_S4 = 8'h33;

    localparam logic [63:0] E_BLOCK = 64'h3C78F1E3C78F1E1E;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
    typedef enum logic [2:0] {BLK_D, BLK_C, BLK_S0, BLK_S4, BLK_T, BLK_E} blk_class_t;

    // Block type byte for a terminate in lane k
    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0: return 8'h87;
            3'd1: return 8'h99;
            3'd2: return 8'hAA;
            3'd3: return 8'hB4;
            3'd4: return 8'hCC;
            3'd5: return 8'hD2;
            3'd6: return 8'hE1;
            3'd7: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/xgmii_block_classify.sv
// Classifies one 8-lane XGMII block into D/C/S0/S4/T/E and reports the terminate lane.
module xgmii_block_classify
    import pcs_pkg::*;
#(
    parameter bit ENABLE_S4 = 1'b1
) (
    input  logic [63:0] blk_data,
    input  logic [7:0]  blk_ctl,
    output blk_class_t  blk_class_c,
    output logic [2:0]  term_lane_c
);

    logic [LANES-1:0] lane_idle;
    logic [LANES-1:0] lane_ci;

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            lane_idle[i] = (blk_data[8*i +: 8] == XGMII_IDLE);
            lane_ci[i]   = lane_idle[i] || (blk_data[8*i +: 8] == XGMII_ERROR);
        end
    end

    always_comb begin
        blk_class_c = BLK_E;
        term_lane_c = 3'd0;
        if (blk_ctl == 8'h00) begin
            blk_class_c = BLK_D;
        end else if (blk_ctl == 8'hFF && (&lane_ci)) begin
            blk_class_c = BLK_C;
        end else if (blk_ctl == 8'h01 && blk_data[7:0] == XGMII_START) begin
            blk_class_c = BLK_S0;
        end else if (ENABLE_S4 && blk_ctl == 8'h1F && blk_data[39:32] == XGMII_START
                     && (&lane_idle[3:0])) begin
            blk_class_c = BLK_S4;
        end else begin
            // Terminate: ctl mask fixes k, so at most one lane can match
            for (int k = 0; k < int'(LANES); k++) begin
                if (blk_data[8*k +: 8] == XGMII_TERM && blk_ctl == 8'(8'hFF << k)
                    && ((lane_idle & 8'(8'hFF << (k + 1))) == 8'(8'hFF << (k + 1)))) begin
                    blk_class_c = BLK_T;
                    term_lane_c = 3'(k);
                end
            end
        end
    end

endmodule

// File: rtl/xgmii_encode_64b66b.sv
// XGMII to 64b/66b block encoder with the TX state machine; 32- or 64-bit XGMII input.
module xgmii_encode_64b66b
    import pcs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          ENABLE_S4  = 1'b1
) (
    input  logic                    i_txc,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_txd,
    input  logic [DATA_WIDTH/8-1:0] i_txctl,
    output logic                    o_valid,
    output logic [63:0]             o_txd,
    output logic [1:0]              o_header,
    output logic                    o_error
);

    logic        blk_done;
    logic [63:0] blk_data;
    logic [7:0]  blk_ctl;

    // Block assembly: 64-bit passes through, 32-bit pairs lower/upper beats
    if (DATA_WIDTH == 64) begin : g_w64
        assign blk_done = i_valid;
        assign blk_data = i_txd;
        assign blk_ctl  = i_txctl;
    end else if (DATA_WIDTH == 32) begin : g_w32
        logic        phase;
        logic [31:0] lo_txd;
        logic [3:0]  lo_ctl;

        always_ff @(posedge i_txc) begin
            if (i_reset) begin
                phase  <= 1'b0;
                lo_txd <= '0;
                lo_ctl <= '0;
            end else if (i_valid) begin
                phase <= ~phase;
                if (!phase) begin
                    lo_txd <= i_txd;
                    lo_ctl <= i_txctl;
                end
            end
        end

        assign blk_done = i_valid & phase;
        assign blk_data = {i_txd, lo_txd};
        assign blk_ctl  = {i_txctl, lo_ctl};
    end else begin : g_bad
        $error("xgmii_encode_64b66b: DATA_WIDTH must be 32 or 64");
    end

    blk_class_t blk_class;
    logic [2:0] term_lane;

    xgmii_block_classify #(.ENABLE_S4(ENABLE_S4)) u_classify (
        .blk_data    (blk_data),
        .blk_ctl     (blk_ctl),
        .blk_class_c (blk_class),
        .term_lane_c (term_lane)
    );

    logic [63:0] enc_txd;
    logic [1:0]  enc_hdr;

    // Encoding of the current block assuming it is legal in sequence
    always_comb begin
        enc_txd = E_BLOCK;
        enc_hdr = HDR_CTRL;
        case (blk_class)
            BLK_D: begin
                enc_txd = blk_data;
                enc_hdr = HDR_DATA;
            end
            BLK_C: begin
                enc_txd = {56'd0, BT_C};
                for (int i = 0; i < int'(LANES); i++)
                    enc_txd[8 + 7*i +: 7] = (blk_data[8*i +: 8] == XGMII_ERROR) ? CODE_ERROR : CODE_IDLE;
            end
            BLK_S0: enc_txd = {blk_data[63:8], BT_S0};
            BLK_S4: enc_txd = {blk_data[63:40], 4'd0, {4{CODE_IDLE}}, BT_S4};
            BLK_T: begin
                enc_txd = {56'd0, term_type(term_lane)};
                for (int i = 0; i < 7; i++)
                    if (i < int'(term_lane)) enc_txd[8*(i+1) +: 8] = blk_data[8*i +: 8];
            end
            default: enc_txd = E_BLOCK;
        endcase
    end

    tx_state_t   state, state_nxt;
    logic        valid_nxt, err_nxt;
    logic [63:0] txd_nxt;
    logic [1:0]  hdr_nxt;

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            state    <= TX_INIT;
            o_valid  <= 1'b0;
            o_txd    <= '0;
            o_header <= 2'b00;
            o_error  <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_valid  <= valid_nxt;
            o_txd    <= txd_nxt;
            o_header <= hdr_nxt;
            o_error  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        txd_nxt   = o_txd;
        hdr_nxt   = o_header;
        err_nxt   = 1'b0;
        if (blk_done) begin
            case (state)
                TX_D: state_nxt = (blk_class == BLK_D) ? TX_D :
                                  (blk_class == BLK_T) ? TX_T : TX_E;
                TX_E: state_nxt = (blk_class == BLK_C) ? TX_C :
                                  (blk_class == BLK_D) ? TX_D :
                                  (blk_class == BLK_T) ? TX_T : TX_E;
                default: state_nxt = (blk_class == BLK_C) ? TX_C :
                                     (blk_class == BLK_S0 || blk_class == BLK_S4) ? TX_D : TX_E;
            endcase
            valid_nxt = 1'b1;
            if (state_nxt == TX_E) begin
                txd_nxt = E_BLOCK;
                hdr_nxt = HDR_CTRL;
                err_nxt = 1'b1;
            end else begin
                txd_nxt = enc_txd;
                hdr_nxt = enc_hdr;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_encode_64b66b.sv
// Bench: 64-bit (S4 on/off) and 32-bit encoders checked against a rule-level reference model.
module tb_xgmii_encode_64b66b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic [63:0] da = '0;
    logic [7:0]  ca = '0;
    logic [31:0] db = '0;
    logic [3:0]  cb = '0;

    logic        ova, ovb, ovc, ea, eb, ec;
    logic [63:0] ta, tb, tc;
    logic [1:0]  ha, hb, hc;

    xgmii_encode_64b66b #(.DATA_WIDTH(64), .ENABLE_S4(1'b1)) dut_a (
        .i_txc(clk), .i_reset(rst), .i_valid(va), .i_txd(da), .i_txctl(ca),
        .o_valid(ova), .o_txd(ta), .o_header(ha), .o_error(ea));
    xgmii_encode_64b66b #(.DATA_WIDTH(32), .ENABLE_S4(1'b1)) dut_b (
        .i_txc(clk), .i_reset(rst), .i_valid(vb), .i_txd(db), .i_txctl(cb),
        .o_valid(ovb), .o_txd(tb), .o_header(hb), .o_error(eb));
    xgmii_encode_64b66b #(.DATA_WIDTH(64), .ENABLE_S4(1'b0)) dut_c (
        .i_txc(clk), .i_reset(rst), .i_valid(va), .i_txd(da), .i_txctl(ca),
        .o_valid(ovc), .o_txd(tc), .o_header(hc), .o_error(ec));

    localparam int R_D = 0, R_C = 1, R_S0 = 2, R_S4 = 3, R_T = 4, R_E = 5;
    localparam int M_INIT = 0, M_C = 1, M_D = 2, M_T = 3, M_E = 4;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] EBLK   = 64'h3C78F1E3C78F1E1E;

    logic [7:0]  ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    int          n_total = 0, n_pass = 0;
    int          st_a = M_INIT, st_b = M_INIT, st_c = M_INIT;
    logic [63:0] lx_a = '0, lx_c = '0;
    logic [63:0] frm_d [11];
    logic [7:0]  frm_c [11];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int ref_class(input logic [63:0] d, input logic [7:0] c, input bit s4,
                                     output int k);
        logic [7:0] ln [8];
        bit ok;
        k = 0;
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        if (c == 8'h00) return R_D;
        if (c == 8'hFF) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++) if (ln[i] != 8'h07 && ln[i] != 8'hFE) ok = 1'b0;
            if (ok) return R_C;
        end
        if (c == 8'h01 && ln[0] == 8'hFB) return R_S0;
        if (s4 && c == 8'h1F && ln[4] == 8'hFB && ln[0] == 8'h07 && ln[1] == 8'h07
            && ln[2] == 8'h07 && ln[3] == 8'h07) return R_S4;
        for (int j = 0; j < 8; j++) begin
            if (ln[j] == 8'hFD) begin
                ok = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (c[i] != (i >= j)) ok = 1'b0;
                    if (i > j && ln[i] != 8'h07) ok = 1'b0;
                end
                if (ok) begin
                    k = j;
                    return R_T;
                end
            end
        end
        return R_E;
    endfunction

    task automatic ref_step(input int st, input logic [63:0] d, input logic [7:0] c, input bit s4,
                            output int st_n, output logic [63:0] e_txd, output logic [1:0] e_hdr,
                            output logic e_err);
        int cl, k;
        cl = ref_class(d, c, s4, k);
        case (st)
            M_D:     st_n = (cl == R_D) ? M_D : (cl == R_T) ? M_T : M_E;
            M_E:     st_n = (cl == R_C) ? M_C : (cl == R_D) ? M_D : (cl == R_T) ? M_T : M_E;
            default: st_n = (cl == R_C) ? M_C : (cl == R_S0 || cl == R_S4) ? M_D : M_E;
        endcase
        e_err = (st_n == M_E);
        e_hdr = (st_n != M_E && cl == R_D) ? 2'b10 : 2'b01;
        if (st_n == M_E) e_txd = EBLK;
        else case (cl)
            R_D:  e_txd = d;
            R_C: begin
                e_txd = 64'h1E;
                for (int i = 0; i < 8; i++)
                    if (d[8*i +: 8] == 8'hFE) e_txd = e_txd + (64'h1E << (8 + 7*i));
            end
            R_S0: e_txd = ((d >> 8) << 8) + 64'h78;
            R_S4: e_txd = ((d >> 40) << 40) + 64'h33;
            default: e_txd = ((d & ((64'd1 << (8*k)) - 64'd1)) << 8) + 64'(ttype[k]);
        endcase
    endtask

    // One 64-bit beat into dut_a and dut_c, then `gap` idle cycles checking hold
    task automatic beat64(input logic [63:0] d, input logic [7:0] c, input int gap);
        logic [63:0] ex;
        logic [1:0]  eh;
        logic        ee;
        int          ns;
        @(negedge clk);
        va = 1'b1; da = d; ca = c;
        @(posedge clk); #1;
        va = 1'b0;
        ref_step(st_a, d, c, 1'b1, ns, ex, eh, ee);
        st_a = ns; lx_a = ex;
        chk("a_valid", 64'(ova), 64'd1);
        chk("a_txd", ta, ex);
        chk("a_hdr", 64'(ha), 64'(eh));
        chk("a_err", 64'(ea), 64'(ee));
        ref_step(st_c, d, c, 1'b0, ns, ex, eh, ee);
        st_c = ns; lx_c = ex;
        chk("c_valid", 64'(ovc), 64'd1);
        chk("c_txd", tc, ex);
        chk("c_hdr", 64'(hc), 64'(eh));
        chk("c_err", 64'(ec), 64'(ee));
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            chk("a_idle_valid", 64'(ova), 64'd0);
            chk("a_hold", ta, lx_a);
            chk("c_idle_valid", 64'(ovc), 64'd0);
            chk("c_hold", tc, lx_c);
        end
    endtask

    task automatic half32(input logic [31:0] d, input logic [3:0] c);
        @(negedge clk);
        vb = 1'b1; db = d; cb = c;
        @(posedge clk); #1;
        vb = 1'b0;
    endtask

    // One block into dut_b as two beats with `gap` empty cycles between them
    task automatic beat32(input logic [63:0] d, input logic [7:0] c, input int gap);
        logic [63:0] ex;
        logic [1:0]  eh;
        logic        ee;
        int          ns;
        half32(d[31:0], c[3:0]);
        chk("b_lo_valid", 64'(ovb), 64'd0);
        repeat (gap) @(posedge clk);
        half32(d[63:32], c[7:4]);
        ref_step(st_b, d, c, 1'b1, ns, ex, eh, ee);
        st_b = ns;
        chk("b_valid", 64'(ovb), 64'd1);
        chk("b_txd", tb, ex);
        chk("b_hdr", 64'(hb), 64'(eh));
        chk("b_err", 64'(eb), 64'(ee));
    endtask

    task automatic gen_blk(output logic [63:0] d, output logic [7:0] c);
        int r, k;
        d = {$urandom, $urandom};
        c = 8'h00;
        r = $urandom_range(0, 11);
        k = $urandom_range(0, 7);
        if (r < 2) begin
            d = IDLE_W; c = 8'hFF;
            if (r == 1) d[8*k +: 8] = 8'hFE;
        end else if (r == 2) begin
            d[7:0] = 8'hFB; c = 8'h01;
        end else if (r == 3) begin
            d[39:0] = 40'hFB07070707; c = 8'h1F;
        end else if (r < 6) begin
            c = 8'(8'hFF << k);
            d[8*k +: 8] = 8'hFD;
            for (int i = k + 1; i < 8; i++) d[8*i +: 8] = 8'h07;
        end else if (r == 11) begin
            c = 8'($urandom);
        end
    endtask

    task automatic reset_models();
        st_a = M_INIT; st_b = M_INIT; st_c = M_INIT;
        lx_a = '0; lx_c = '0;
    endtask

    initial begin
        logic [63:0] rd;
        logic [7:0]  rc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", 64'(ova), 64'd0);
        chk("rst_a_txd", ta, 64'd0);
        chk("rst_a_hdr", 64'(ha), 64'd0);
        chk("rst_a_err", 64'(ea), 64'd0);
        chk("rst_b_valid", 64'(ovb), 64'd0);
        chk("rst_b_txd", tb, 64'd0);
        chk("rst_b_hdr", 64'(hb), 64'd0);
        chk("rst_c_valid", 64'(ovc), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Standard frame, 64-bit
        frm_d[0] = IDLE_W;                 frm_c[0] = 8'hFF;
        frm_d[1] = 64'hD5555555555555FB;   frm_c[1] = 8'h01;
        for (int i = 2; i < 10; i++) begin
            frm_d[i] = {$urandom, $urandom}; frm_c[i] = 8'h00;
        end
        frm_d[10] = 64'h07070707070707FD;  frm_c[10] = 8'hFF;
        beat64(frm_d[0], frm_c[0], 1);
        beat64(frm_d[1], frm_c[1], 0);
        chk("t1_start", ta, 64'hD555555555555578);
        for (int i = 2; i < 10; i++) begin
            beat64(frm_d[i], frm_c[i], 0);
            chk("t1_data_hdr", 64'(ha), 64'h2);
        end
        beat64(frm_d[10], frm_c[10], 1);
        chk("t1_term", ta, 64'h0000000000000087);

        // Same frame, 32-bit with gaps
        for (int i = 0; i < 11; i++) beat32(frm_d[i], frm_c[i], i % 3);
        chk("t2_term", tb, 64'h0000000000000087);

        // Terminate in lane 3 after data, then idle
        beat64(64'hD5555555555555FB, 8'h01, 0);
        beat64(64'h0123456789ABCDEF, 8'h00, 0);
        beat64(64'h07070707FDCCBBAA, 8'hF8, 0);
        chk("t3_term3", ta, 64'h00000000CCBBAAB4);
        beat64(IDLE_W, 8'hFF, 0);

        // Data directly after idle
        beat64(64'h1122334455667788, 8'h00, 0);
        chk("t4_eblk", ta, EBLK);
        chk("t4_err", 64'(ea), 64'd1);
        beat64(IDLE_W, 8'hFF, 1);
        chk("t4_idle", ta, 64'h1E);
        chk("t4_idle_err", 64'(ea), 64'd0);

        // Start in lane 4: encoded with ENABLE_S4, E-block without
        beat64(64'hD55555FB07070707, 8'h1F, 0);
        chk("t5_s4", ta, 64'hD555550000000033);
        chk("t5_s4_off", tc, EBLK);
        chk("t5_s4_off_err", 64'(ec), 64'd1);
        beat64(64'h0F0E0D0C0B0A0908, 8'h00, 0);

        // Reset mid-frame, 64-bit: reset beats i_valid
        @(negedge clk);
        rst = 1'b1; va = 1'b1; da = 64'hAAAA5555AAAA5555; ca = 8'h00;
        @(posedge clk); #1;
        va = 1'b0;
        reset_models();
        chk("t6_valid", 64'(ova), 64'd0);
        chk("t6_txd", ta, 64'd0);
        chk("t6_hdr", 64'(ha), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat64(64'hAAAA5555AAAA5555, 8'h00, 0);
        chk("t6_eblk", ta, EBLK);
        chk("t6_err", 64'(ea), 64'd1);

        // Reset mid-block, 32-bit: stale lower half discarded
        beat32(IDLE_W, 8'hFF, 0);
        beat32(64'hD5555555555555FB, 8'h01, 0);
        half32(32'h12345678, 4'h0);
        @(negedge clk);
        rst = 1'b1; vb = 1'b1; db = 32'h9ABCDEF0; cb = 4'h0;
        @(posedge clk); #1;
        vb = 1'b0;
        reset_models();
        chk("t6_b_valid", 64'(ovb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat32(IDLE_W, 8'hFF, 1);
        chk("t6_b_idle", tb, 64'h1E);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            gen_blk(rd, rc);
            beat64(rd, rc, $urandom_range(0, 1));
        end
        for (int n = 0; n < 120; n++) begin
            gen_blk(rd, rc);
            beat32(rd, rc, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
